// File: rtl/unified_mem_arbiter.sv
// Shares one single-port SRAM between CPU fetch (IF), CPU data (DM) and a program loader (LD).
// LOAD mode grants only the loader; RUN arbitrates DM over IF with an IF starvation guard.
module unified_mem_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [3:0]        dm_w_en,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    input  logic              ld_done,
    input  logic              halt,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [3:0]        sram_w_en,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    typedef enum logic [1:0] {StLoad, StRun, StHalt} state_e;
    typedef enum logic [1:0] {TagNone, TagIf, TagDm} tag_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    state_e            state_q;
    tag_e              tag_q, tag_d;
    logic [3:0]        starve_q, starve_d;
    logic              cpu_hold_q;
    logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

    // Grants are gated by reset so nothing reaches the SRAM while rst is low.
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        ld_gnt = 1'b0;
        if (rst) begin
            unique case (state_q)
                StLoad: ld_gnt = ld_req;
                StRun: begin
                    if_gnt = if_req && (!dm_req || starve_q == StarveMax);
                    dm_gnt = dm_req && !if_gnt;
                end
                StHalt: dm_gnt = dm_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        sram_addr  = '0;
        sram_w_en  = 4'h0;
        sram_wdata = '0;
        if (ld_gnt) begin
            sram_addr  = ld_addr;
            sram_w_en  = 4'hF;
            sram_wdata = ld_wdata;
        end else if (dm_gnt) begin
            sram_addr  = dm_addr;
            sram_w_en  = dm_w_en;
            sram_wdata = dm_wdata;
        end else if (if_gnt) begin
            sram_addr  = if_addr;
        end
    end

    always_comb begin
        tag_d = TagNone;
        if (if_gnt) begin
            tag_d = TagIf;
        end else if (dm_gnt && dm_w_en == 4'h0) begin
            tag_d = TagDm;
        end
        starve_d = 4'h0;
        if (state_q == StRun && if_req && !if_gnt) begin
            starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'h1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StLoad;
            cpu_hold_q <= 1'b1;
        end else begin
            unique case (state_q)
                StLoad: if (ld_done) begin
                    state_q    <= StRun;
                    cpu_hold_q <= 1'b0;
                end
                StRun: if (halt) begin
                    state_q    <= StHalt;
                    cpu_hold_q <= 1'b1;
                end
                StHalt: if (ld_req) begin
                    state_q    <= StLoad;
                    cpu_hold_q <= 1'b1;
                end
                default: begin
                    state_q    <= StLoad;
                    cpu_hold_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q      <= TagNone;
            starve_q   <= 4'h0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            tag_q    <= tag_d;
            starve_q <= starve_d;
            if (tag_q == TagIf) if_rdata_q <= sram_rdata;
            if (tag_q == TagDm) dm_rdata_q <= sram_rdata;
        end
    end

    assign if_rvalid = (tag_q == TagIf);
    assign dm_rvalid = (tag_q == TagDm);
    assign if_rdata  = if_rvalid ? sram_rdata : if_rdata_q;
    assign dm_rdata  = dm_rvalid ? sram_rdata : dm_rdata_q;
    assign cpu_hold  = cpu_hold_q;

endmodule
